// File: rtl/tcu_reg_responder.sv
// Target side of the TCU register interface. Holds a small register file
// with bit-wise write merge and per-source write protection. One register
// is a command register that hands its contents to the TCU control logic
// through a valid/ready/done handshake.
//
// Command handshake: cmd_valid_o is held while the command waits for the
// control logic. The transfer happens on the cycle where cmd_valid_o and
// cmd_ready_i are both high. Completion is reported later by a one-cycle
// pulse on cmd_done_i. From the accepting write until done, the command
// is busy. CMD writes stall for that whole time, so cmd_data_o stays stable.
module tcu_reg_responder #(
   parameter int                  TCU_REG_DATA_SIZE = 64,
   parameter int                  TCU_REG_ADDR_SIZE = 32,
   parameter int                  NUM_REGS          = 16,
   parameter int                  CMD_IDX           = 0,
   parameter logic [NUM_REGS-1:0] EXT_WR_MASK       = 16'h00FE,
   parameter logic [NUM_REGS-1:0] CORE_WR_MASK      = 16'h0001
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [2:0]                   reg_en_i,
   input  logic [TCU_REG_DATA_SIZE-1:0] reg_wben_i,
   input  logic [TCU_REG_ADDR_SIZE-1:0] reg_addr_i,
   input  logic [TCU_REG_DATA_SIZE-1:0] reg_wdata_i,
   output logic [TCU_REG_DATA_SIZE-1:0] reg_rdata_o,
   output logic                         reg_stall_o,
   output logic                         reg_err_o,
   output logic                         cmd_valid_o,
   output logic [TCU_REG_DATA_SIZE-1:0] cmd_data_o,
   input  logic                         cmd_ready_i,
   input  logic                         cmd_done_i
);

   localparam int               IDX_W   = $clog2(NUM_REGS);
   localparam logic [IDX_W-1:0] CMD_SEL = IDX_W'(CMD_IDX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                         state_q;
   state_t                         state_d;
   logic [TCU_REG_DATA_SIZE-1:0]   regs [NUM_REGS];

   logic [IDX_W-1:0]               idx;
   logic                           out_of_range;
   logic                           is_write;
   logic                           busy;
   logic                           accept;
   logic                           permitted;
   logic                           wr_ok;
   logic                           rd_ok;
   logic                           err_set;
   logic                           cmd_start;
   logic [TCU_REG_DATA_SIZE-1:0]   rd_value;

   // Decode the access, apply stall and protection rules
   always_comb begin
      idx          = reg_addr_i[3 +: IDX_W];
      out_of_range = (reg_addr_i[2:0] != 3'b000) |
                     (reg_addr_i[TCU_REG_ADDR_SIZE-1:3+IDX_W] != '0);
      is_write     = |reg_wben_i;
      busy         = (state_q != ST_IDLE);
      reg_stall_o  = reg_en_i[0] & is_write & ~out_of_range & (idx == CMD_SEL) & busy;
      accept       = reg_en_i[0] & ~reg_stall_o;
      permitted    = (~reg_en_i[1] | EXT_WR_MASK[idx]) & (~reg_en_i[2] | CORE_WR_MASK[idx]);
      wr_ok        = accept & is_write & ~out_of_range & permitted;
      rd_ok        = accept & ~is_write;
      err_set      = accept & (out_of_range | (is_write & ~permitted));
      cmd_start    = wr_ok & (idx == CMD_SEL);
   end

   // Read mux: the command register reports busy in its top bit
   always_comb begin
      rd_value = regs[idx];
      if (idx == CMD_SEL) begin
         rd_value[TCU_REG_DATA_SIZE-1] = busy;
      end
      if (out_of_range) begin
         rd_value = '0;
      end
   end

   // Register file with bit-wise write merge
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[idx] <= (regs[idx] & ~reg_wben_i) | (reg_wdata_i & reg_wben_i);
      end
   end

   // Registered read data and error pulse
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         reg_rdata_o <= '0;
         reg_err_o   <= 1'b0;
      end else begin
         reg_err_o <= err_set;
         if (rd_ok) begin
            reg_rdata_o <= rd_value;
         end
      end
   end

   // Command FSM state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command FSM next state; done is only meaningful after ready was taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_start)   state_d = ST_REQ;
         ST_REQ:  if (cmd_ready_i) state_d = ST_WAIT;
         ST_WAIT: if (cmd_done_i)  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Command FSM outputs
   always_comb begin
      cmd_valid_o = (state_q == ST_REQ);
      cmd_data_o  = regs[CMD_SEL];
   end

endmodule

// File: tb/tb_tcu_reg_responder.sv
// Testbench for tcu_reg_responder: register merge, protection, command
// handshake with stall, out-of-range accesses and reset mid-command.
module tb_tcu_reg_responder;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [2:0]  reg_en;
   logic [63:0] reg_wben;
   logic [31:0] reg_addr;
   logic [63:0] reg_wdata;
   logic [63:0] reg_rdata;
   logic        reg_stall;
   logic        reg_err;
   logic        cmd_valid;
   logic [63:0] cmd_data;
   logic        cmd_ready;
   logic        cmd_done;

   logic [63:0] exp_q[$];
   logic [63:0] mdl [16];
   logic        mdl_busy;
   int          n_checks = 0;
   int          n_fail   = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   tcu_reg_responder dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .reg_en_i    (reg_en),
      .reg_wben_i  (reg_wben),
      .reg_addr_i  (reg_addr),
      .reg_wdata_i (reg_wdata),
      .reg_rdata_o (reg_rdata),
      .reg_stall_o (reg_stall),
      .reg_err_o   (reg_err),
      .cmd_valid_o (cmd_valid),
      .cmd_data_o  (cmd_data),
      .cmd_ready_i (cmd_ready),
      .cmd_done_i  (cmd_done)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // expected read value from the model (busy shown in bit 63 of idx 0)
   function automatic logic [63:0] exp_read(input int idx);
      logic [63:0] v;
      v = mdl[idx];
      if (idx == 0) v[63] = mdl_busy;
      return v;
   endfunction

   task automatic mdl_wr(input int idx, input logic [63:0] wben, input logic [63:0] wdata);
      mdl[idx] = (mdl[idx] & ~wben) | (wdata & wben);
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      mdl_busy = 1'b0;
   endtask

   // driver: one access held for one clock, called and returning at negedge
   task automatic access(input logic [2:0] en, input logic [63:0] wben,
                         input logic [31:0] addr, input logic [63:0] wdata);
      reg_en = en; reg_wben = wben; reg_addr = addr; reg_wdata = wdata;
      @(negedge clk);
      reg_en = 3'b000; reg_wben = '0; reg_addr = '0; reg_wdata = '0;
   endtask

   // driver: read with expected value pushed to the scoreboard
   task automatic issue_read(input logic [31:0] addr, input logic [63:0] expv);
      exp_q.push_back(expv);
      access(3'b001, 64'd0, addr, 64'd0);
   endtask

   task automatic test_reset();
      logic [63:0] e;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
      n_checks++; if (reg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", reg_err); end
      n_checks++; if (reg_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", reg_stall); end
      n_checks++; if (reg_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", reg_rdata); end
      for (int i = 0; i < 16; i++) begin
         issue_read(32'(i) << 3, 64'd0);
         e = exp_q.pop_front();
         n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL reset_read idx%0d: got %h expected %h", i, reg_rdata, e); end
         n_checks++; if (reg_err !== 1'b0) begin n_fail++; $display("FAIL reset_read_err idx%0d: got %b expected 0", i, reg_err); end
      end
   endtask

   task automatic test_write_merge();
      logic [63:0] e, wb, wd;
      int          idx;
      access(3'b001, 64'h0000_FFFF_FFFF_0000, 32'h18, 64'hFFFF_0000_FFFF_0000);
      mdl_wr(3, 64'h0000_FFFF_FFFF_0000, 64'hFFFF_0000_FFFF_0000);
      n_checks++; if (reg_err !== 1'b0) begin n_fail++; $display("FAIL merge_err: got %b expected 0", reg_err); end
      n_checks++; if (reg_rdata !== 64'd0) begin n_fail++; $display("FAIL merge_rdata_held: got %h expected 0", reg_rdata); end
      issue_read(32'h18, 64'h0000_0000_FFFF_0000);
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL merge_idx3: got %h expected %h", reg_rdata, e); end
      for (int k = 0; k < 6; k++) begin
         idx = $urandom_range(1, 15);
         wb  = {$urandom, $urandom};
         wd  = {$urandom, $urandom};
         access(3'b001, wb, 32'(idx) << 3, wd);
         mdl_wr(idx, wb, wd);
         issue_read(32'(idx) << 3, exp_read(idx));
         e = exp_q.pop_front();
         n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL merge_rand idx%0d: got %h expected %h", idx, reg_rdata, e); end
      end
   endtask

   task automatic test_protection();
      logic [63:0] e;
      access(3'b011, ONES, 32'h0, 64'hDEAD);
      n_checks++; if (reg_err !== 1'b1) begin n_fail++; $display("FAIL ext_cmd_err: got %b expected 1", reg_err); end
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL ext_cmd_no_start: got %b expected 0", cmd_valid); end
      @(negedge clk);
      n_checks++; if (reg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_end: got %b expected 0", reg_err); end
      issue_read(32'h0, exp_read(0));
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL ext_cmd_unchanged: got %h expected %h", reg_rdata, e); end
      access(3'b011, ONES, 32'h28, 64'h55);
      mdl_wr(5, ONES, 64'h55);
      n_checks++; if (reg_err !== 1'b0) begin n_fail++; $display("FAIL ext_idx5_err: got %b expected 0", reg_err); end
      access(3'b101, ONES, 32'h28, 64'h77);
      n_checks++; if (reg_err !== 1'b1) begin n_fail++; $display("FAIL core_idx5_err: got %b expected 1", reg_err); end
      issue_read(32'h28, exp_read(5));
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL idx5_value: got %h expected %h", reg_rdata, e); end
      access(3'b101, ONES, 32'h0, 64'd5);
      mdl_wr(0, ONES, 64'd5);
      mdl_busy = 1'b1;
      n_checks++; if (reg_err !== 1'b0) begin n_fail++; $display("FAIL core_cmd_err: got %b expected 0", reg_err); end
      n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL core_cmd_valid: got %b expected 1", cmd_valid); end
      n_checks++; if (cmd_data !== 64'd5) begin n_fail++; $display("FAIL core_cmd_data: got %h expected 5", cmd_data); end
   endtask

   task automatic test_cmd_stall();
      logic [63:0] e;
      issue_read(32'h0, exp_read(0));
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL busy_read: got %h expected %h", reg_rdata, e); end
      // done while still in REQ must be ignored
      cmd_done = 1'b1; @(negedge clk); cmd_done = 1'b0;
      n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL done_in_req: got %b expected 1", cmd_valid); end
      // second CMD write, held while stalled
      reg_en = 3'b101; reg_wben = ONES; reg_addr = 32'h0; reg_wdata = 64'd9;
      #1;
      n_checks++; if (reg_stall !== 1'b1) begin n_fail++; $display("FAIL stall_req: got %b expected 1", reg_stall); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++; if (reg_stall !== 1'b1 || cmd_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_req: stall %b valid %b expected 1 1", reg_stall, cmd_valid); end
      end
      cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
      n_checks++; if (cmd_valid !== 1'b0 || reg_stall !== 1'b1) begin n_fail++; $display("FAIL wait_state: valid %b stall %b expected 0 1", cmd_valid, reg_stall); end
      n_checks++; if (cmd_data !== 64'd5) begin n_fail++; $display("FAIL cmd_data_stable: got %h expected 5", cmd_data); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++; if (reg_stall !== 1'b1) begin n_fail++; $display("FAIL stall_hold_wait: got %b expected 1", reg_stall); end
      end
      cmd_done = 1'b1; #1;
      n_checks++; if (reg_stall !== 1'b1) begin n_fail++; $display("FAIL stall_with_done: got %b expected 1", reg_stall); end
      @(negedge clk); cmd_done = 1'b0;
      n_checks++; if (reg_stall !== 1'b0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: stall %b valid %b expected 0 0", reg_stall, cmd_valid); end
      @(negedge clk);
      reg_en = 3'b000; reg_wben = '0; reg_addr = '0; reg_wdata = '0;
      mdl_wr(0, ONES, 64'd9);
      mdl_busy = 1'b1;
      n_checks++; if (cmd_valid !== 1'b1 || cmd_data !== 64'd9) begin n_fail++; $display("FAIL second_cmd: valid %b data %h expected 1 9", cmd_valid, cmd_data); end
      issue_read(32'h0, exp_read(0));
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL second_cmd_read: got %h expected %h", reg_rdata, e); end
      cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
      cmd_done  = 1'b1; @(negedge clk); cmd_done  = 1'b0;
      mdl_busy = 1'b0;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cmd_finished: got %b expected 0", cmd_valid); end
      issue_read(32'h0, exp_read(0));
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL idle_cmd_read: got %h expected %h", reg_rdata, e); end
   endtask

   task automatic test_out_of_range();
      logic [63:0] e;
      issue_read(32'h18, exp_read(3));
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL oor_pre_read: got %h expected %h", reg_rdata, e); end
      @(negedge clk);
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL rdata_hold: got %h expected %h", reg_rdata, e); end
      issue_read(32'h100, 64'd0);
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e || reg_err !== 1'b1) begin n_fail++; $display("FAIL oor_read_0x100: rdata %h err %b expected %h 1", reg_rdata, reg_err, e); end
      issue_read(32'h18, exp_read(3));
      e = exp_q.pop_front();
      issue_read(32'h4, 64'd0);
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e || reg_err !== 1'b1) begin n_fail++; $display("FAIL oor_read_0x4: rdata %h err %b expected %h 1", reg_rdata, reg_err, e); end
      access(3'b001, ONES, 32'h100, ONES);
      n_checks++; if (reg_err !== 1'b1 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL oor_write_0x100: err %b valid %b expected 1 0", reg_err, cmd_valid); end
      access(3'b001, ONES, 32'h1B, ONES);
      n_checks++; if (reg_err !== 1'b1) begin n_fail++; $display("FAIL oor_write_0x1b: got %b expected 1", reg_err); end
      for (int i = 0; i < 4; i++) begin
         issue_read(32'(i) << 3, exp_read(i));
         e = exp_q.pop_front();
         n_checks++; if (reg_rdata !== e || reg_err !== 1'b0) begin n_fail++; $display("FAIL oor_no_change idx%0d: rdata %h err %b expected %h 0", i, reg_rdata, reg_err, e); end
      end
   endtask

   task automatic test_reset_mid_cmd();
      logic [63:0] e;
      access(3'b101, ONES, 32'h0, 64'd7);
      n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", cmd_valid); end
      reset_i = 1'b1; #1;
      n_checks++; if (cmd_valid !== 1'b0 || cmd_data !== 64'd0 || reg_rdata !== 64'd0) begin n_fail++; $display("FAIL async_reset: valid %b data %h rdata %h expected 0 0 0", cmd_valid, cmd_data, reg_rdata); end
      @(negedge clk); reset_i = 1'b0;
      mdl_clear();
      for (int i = 0; i < 4; i++) begin
         issue_read(32'(i) << 3, exp_read(i));
         e = exp_q.pop_front();
         n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL post_reset_read idx%0d: got %h expected %h", i, reg_rdata, e); end
      end
      access(3'b101, ONES, 32'h0, 64'h11);
      mdl_wr(0, ONES, 64'h11);
      mdl_busy = 1'b1;
      n_checks++; if (cmd_valid !== 1'b1 || cmd_data !== 64'h11) begin n_fail++; $display("FAIL restart_cmd: valid %b data %h expected 1 11", cmd_valid, cmd_data); end
      cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL restart_ready: got %b expected 0", cmd_valid); end
      cmd_done = 1'b1; @(negedge clk); cmd_done = 1'b0;
      mdl_busy = 1'b0;
      issue_read(32'h0, exp_read(0));
      e = exp_q.pop_front();
      n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL restart_read: got %h expected %h", reg_rdata, e); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] e, wd;
      int          idx [8];
      for (int k = 0; k < 8; k++) begin
         idx[k] = $urandom_range(1, 15);
         wd = {$urandom, $urandom};
         reg_en = 3'b001; reg_wben = ONES; reg_addr = 32'(idx[k]) << 3; reg_wdata = wd;
         mdl_wr(idx[k], ONES, wd);
         @(negedge clk);
      end
      for (int k = 0; k < 8; k++) begin
         reg_en = 3'b001; reg_wben = '0; reg_addr = 32'(idx[k]) << 3; reg_wdata = '0;
         exp_q.push_back(exp_read(idx[k]));
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++; if (reg_rdata !== e) begin n_fail++; $display("FAIL b2b_read idx%0d: got %h expected %h", idx[k], reg_rdata, e); end
      end
      reg_en = 3'b000; reg_addr = '0;
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
   endtask

   initial begin
      reset_i = 1'b1;
      reg_en = 3'b000; reg_wben = '0; reg_addr = '0; reg_wdata = '0;
      cmd_ready = 1'b0; cmd_done = 1'b0;
      mdl_clear();
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      test_reset();
      test_write_merge();
      test_protection();
      test_cmd_stall();
      test_out_of_range();
      test_reset_mid_cmd();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
